// File: rtl/mips_pkg.sv
// Shared ISA constants, ALU encodings and controller state set for the
// multicycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_RTWB    = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEXE = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side,
// slave = datapath side.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal;

  modport master (
    input  op, funct, zero, memready,
    output memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero, memready,
    input  memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: aluop plus R-type funct field to alucontrol.
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_AND;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alucontrol = ALU_ADD;
          FN_SUB:  o_alucontrol = ALU_SUB;
          FN_AND:  o_alucontrol = ALU_AND;
          FN_OR:   o_alucontrol = ALU_OR;
          FN_SLT:  o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_AND;
        endcase
      end
      default: o_alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle MIPS core with memory-ready stalls.
//   state   | meaning
//   FETCH   | read instr at PC, PC+4 -> PC, wait memready
//   DECODE  | branch target into ALUOut, dispatch on op
//   MEMADR  | lw/sw effective address
//   MEMRD   | data read at ALUOut, wait memready
//   MEMWB   | load data -> rt
//   MEMWR   | data write at ALUOut, wait memready
//   RTEXE   | R-type ALU op
//   RTWB    | ALUOut -> rd
//   BEQ     | compare, PC <- ALUOut if zero
//   ADDIEXE | A + SignImm
//   ADDIWB  | ALUOut -> rt
//   JUMP    | PC <- jump target
module multicycle_controller
  import mips_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  multicycle_controller_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_state_eff;
  aluop_t     w_aluop;
  logic       w_pcwrite, w_branch, w_irwrite, w_memwrite, w_regwrite;
  logic       w_illegal;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = bus.memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTEXE;
          OP_BEQ:       w_next = S_BEQ;
          OP_ADDI:      w_next = S_ADDIEXE;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      w_next = S_MEMRD;
        else if (bus.op == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_FETCH;
      end
      S_MEMRD:   w_next = bus.memready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = bus.memready ? S_FETCH : S_MEMWR;
      S_RTEXE:   w_next = S_RTWB;
      S_RTWB:    w_next = S_FETCH;
      S_BEQ:     w_next = S_FETCH;
      S_ADDIEXE: w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Under reset the selects show FETCH values regardless of the held state.
  assign w_state_eff = reset ? S_FETCH : r_state;

  always_comb begin
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_irwrite    = 1'b0;
    w_memwrite   = 1'b0;
    w_regwrite   = 1'b0;
    w_illegal    = 1'b0;
    w_aluop      = ALUOP_ADD;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    case (w_state_eff)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        w_irwrite   = bus.memready;
        w_pcwrite   = bus.memready;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        w_illegal   = !is_legal_op(bus.op);
      end
      S_MEMADR, S_ADDIEXE: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: bus.iord = 1'b1;
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        w_regwrite   = 1'b1;
      end
      S_MEMWR: begin
        bus.iord   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTEXE: begin
        bus.alusrca = 1'b1;
        w_aluop     = ALUOP_FUNCT;
      end
      S_RTWB: begin
        bus.regdst = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQ: begin
        bus.alusrca = 1'b1;
        w_aluop     = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        w_branch    = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        bus.pcsrc = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.irwrite  = w_irwrite  & ~reset;
  assign bus.memwrite = w_memwrite & ~reset;
  assign bus.regwrite = w_regwrite & ~reset;
  assign bus.illegal  = w_illegal  & ~reset;
  assign bus.pcen     = (w_pcwrite | (w_branch & bus.zero)) & ~reset;

  alu_decoder u_alu_decoder (
    .i_aluop      (w_aluop),
    .i_funct      (bus.funct),
    .o_alucontrol (bus.alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: per-cycle state and
// output vector checks against hand-computed values.
module tb_multicycle_controller;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,pcen,alucontrol,illegal}
  function automatic logic [15:0] vec(input logic mw, input logic ir, input logic rw,
                                      input logic io, input logic mt, input logic rd,
                                      input logic sa, input logic [1:0] sb,
                                      input logic [1:0] pc, input logic pe,
                                      input logic [2:0] ac, input logic il);
    return {mw, ir, rw, io, mt, rd, sa, sb, pc, pe, ac, il};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.memwrite, bus.irwrite, bus.regwrite, bus.iord, bus.memtoreg,
            bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
            bus.alucontrol, bus.illegal};
  endfunction

  logic [15:0] V_FETCH, V_IDLE, V_DECODE, V_ILL, V_MEMADR, V_MEMRD, V_MEMWB, V_MEMWR;
  logic [15:0] V_RTWB, V_ADDIWB, V_JUMP;

  // Compare state and outputs mid-cycle, then advance one clock.
  task automatic cyc(input string tag, input state_t exp_state, input logic [15:0] exp_vec);
    logic [15:0] o;
    logic [3:0]  s;
    #1;
    o = obs();
    s = dut.r_state;
    n_total++;
    assert (s === exp_state) else begin
      n_bad++;
      $error("FAIL %s state: got %0d want %0d", tag, s, exp_state);
    end
    n_total++;
    assert (o === exp_vec) else begin
      n_bad++;
      $error("FAIL %s outputs: got %b want %b", tag, o, exp_vec);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    V_FETCH  = vec(0,1,0,0,0,0,0,2'b01,2'b00,1,3'b010,0);
    V_IDLE   = vec(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0);
    V_DECODE = vec(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0);
    V_ILL    = vec(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,1);
    V_MEMADR = vec(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
    V_MEMRD  = vec(0,0,0,1,0,0,0,2'b00,2'b00,0,3'b010,0);
    V_MEMWB  = vec(0,0,1,0,1,0,0,2'b00,2'b00,0,3'b010,0);
    V_MEMWR  = vec(1,0,0,1,0,0,0,2'b00,2'b00,0,3'b010,0);
    V_RTWB   = vec(0,0,1,0,0,1,0,2'b00,2'b00,0,3'b010,0);
    V_ADDIWB = vec(0,0,1,0,0,0,0,2'b00,2'b00,0,3'b010,0);
    V_JUMP   = vec(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0);

    reset = 1'b1;
    bus.op = OP_LW;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    bus.memready = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", S_FETCH, V_IDLE);
    reset = 1'b0;

    // lw, 5 cycles
    bus.op = OP_LW;
    cyc("lw.fetch",  S_FETCH,  V_FETCH);
    cyc("lw.decode", S_DECODE, V_DECODE);
    cyc("lw.memadr", S_MEMADR, V_MEMADR);
    cyc("lw.memrd",  S_MEMRD,  V_MEMRD);
    cyc("lw.memwb",  S_MEMWB,  V_MEMWB);

    // R-type sub
    bus.op = OP_RTYPE;
    bus.funct = FN_SUB;
    cyc("sub.fetch",  S_FETCH,  V_FETCH);
    cyc("sub.decode", S_DECODE, V_DECODE);
    cyc("sub.rtexe",  S_RTEXE,  vec(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b110,0));
    cyc("sub.rtwb",   S_RTWB,   V_RTWB);

    // beq taken, then not taken
    bus.op = OP_BEQ;
    bus.zero = 1'b1;
    cyc("beq1.fetch",  S_FETCH,  V_FETCH);
    cyc("beq1.decode", S_DECODE, V_DECODE);
    cyc("beq1.beq",    S_BEQ,    vec(0,0,0,0,0,0,1,2'b00,2'b01,1,3'b110,0));
    bus.zero = 1'b0;
    cyc("beq0.fetch",  S_FETCH,  V_FETCH);
    cyc("beq0.decode", S_DECODE, V_DECODE);
    cyc("beq0.beq",    S_BEQ,    vec(0,0,0,0,0,0,1,2'b00,2'b01,0,3'b110,0));

    // fetch stall 3 cycles, then sw with 2-cycle write stall
    bus.op = OP_SW;
    bus.memready = 1'b0;
    cyc("stall.f0", S_FETCH, V_IDLE);
    cyc("stall.f1", S_FETCH, V_IDLE);
    cyc("stall.f2", S_FETCH, V_IDLE);
    bus.memready = 1'b1;
    cyc("stall.f3",   S_FETCH,  V_FETCH);
    cyc("sw.decode",  S_DECODE, V_DECODE);
    cyc("sw.memadr",  S_MEMADR, V_MEMADR);
    bus.memready = 1'b0;
    cyc("sw.memwr0",  S_MEMWR,  V_MEMWR);
    cyc("sw.memwr1",  S_MEMWR,  V_MEMWR);
    bus.memready = 1'b1;
    cyc("sw.memwr2",  S_MEMWR,  V_MEMWR);

    // addi, with memready low where it must be ignored
    bus.op = OP_ADDI;
    cyc("addi.fetch",  S_FETCH,   V_FETCH);
    bus.memready = 1'b0;
    cyc("addi.decode", S_DECODE,  V_DECODE);
    cyc("addi.exe",    S_ADDIEXE, V_MEMADR);
    cyc("addi.wb",     S_ADDIWB,  V_ADDIWB);
    bus.memready = 1'b1;

    // illegal opcode
    bus.op = 6'b111111;
    cyc("ill.fetch",  S_FETCH,  V_FETCH);
    cyc("ill.decode", S_DECODE, V_ILL);

    // jump
    bus.op = OP_J;
    cyc("j.fetch",  S_FETCH,  V_FETCH);
    cyc("j.decode", S_DECODE, V_DECODE);
    cyc("j.jump",   S_JUMP,   V_JUMP);

    // R-type and/slt/unknown funct
    bus.op = OP_RTYPE;
    bus.funct = FN_AND;
    cyc("and.fetch",  S_FETCH,  V_FETCH);
    cyc("and.decode", S_DECODE, V_DECODE);
    cyc("and.rtexe",  S_RTEXE,  vec(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b000,0));
    bus.funct = FN_SLT;
    cyc("slt.rtwb",   S_RTWB,   V_RTWB);
    cyc("slt.fetch",  S_FETCH,  V_FETCH);
    cyc("slt.decode", S_DECODE, V_DECODE);
    cyc("slt.rtexe",  S_RTEXE,  vec(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b111,0));
    bus.funct = FN_OR;
    cyc("or.rtwb",    S_RTWB,   V_RTWB);
    cyc("or.fetch",   S_FETCH,  V_FETCH);
    cyc("or.decode",  S_DECODE, V_DECODE);
    cyc("or.rtexe",   S_RTEXE,  vec(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b001,0));
    bus.funct = 6'b111111;
    cyc("unk.rtwb",   S_RTWB,   V_RTWB);
    cyc("unk.fetch",  S_FETCH,  V_FETCH);
    cyc("unk.decode", S_DECODE, V_DECODE);
    cyc("unk.rtexe",  S_RTEXE,  vec(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b000,0));
    cyc("unk.rtwb",   S_RTWB,   V_RTWB);

    // reset while stalled in MEMRD
    bus.op = OP_LW;
    cyc("rst.fetch",  S_FETCH,  V_FETCH);
    cyc("rst.decode", S_DECODE, V_DECODE);
    cyc("rst.memadr", S_MEMADR, V_MEMADR);
    bus.memready = 1'b0;
    cyc("rst.memrd",  S_MEMRD,  V_MEMRD);
    bus.memready = 1'b1;
    reset = 1'b1;
    cyc("rst.held",   S_MEMRD,  V_IDLE);
    reset = 1'b0;
    cyc("rst.fetch2",  S_FETCH,  V_FETCH);
    cyc("rst.decode2", S_DECODE, V_DECODE);
    cyc("rst.memadr2", S_MEMADR, V_MEMADR);
    cyc("rst.memrd2",  S_MEMRD,  V_MEMRD);
    cyc("rst.memwb2",  S_MEMWB,  V_MEMWB);
    cyc("rst.after",   S_FETCH,  V_FETCH);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
